// File: rtl/simple_dma_reader_if.sv
// Bus bundle for simple_dma_reader: transfer control, memory read port and pixel stream.
interface simple_dma_reader_if;
    logic        start;
    logic [15:0] base;
    logic [15:0] len;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic [15:0] bytes_sent;
    logic        busy;
    logic        done;

    // slave: the DMA engine side
    modport slave (
        input  start, base, len, rd_data, pix_ready,
        output rd_en, rd_addr, pix_valid, pix_data, bytes_sent, busy, done
    );

    // master: the controller / memory / sink side
    modport master (
        output start, base, len, rd_data, pix_ready,
        input  rd_en, rd_addr, pix_valid, pix_data, bytes_sent, busy, done
    );
endinterface

// File: rtl/simple_dma_reader.sv
// Memory-to-stream DMA: issues credit-limited reads into a small FIFO and streams bytes out.
module simple_dma_reader #(
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    simple_dma_reader_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0] DEPTH_C = 8'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [15:0]           base_q, len_q, issued_q, sent_q, rd_addr_q;
    logic                  rd_en_q, done_q;
    logic [RD_LATENCY-1:0] vld_p;
    logic [7:0]            fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  accept, issue_go, done_d, push, pop, pix_valid;
    logic [7:0]            outstanding;

    function automatic logic [7:0] inflight(input logic en, input logic [RD_LATENCY-1:0] v);
        logic [7:0] n;
        n = {7'd0, en};
        for (int i = 0; i < RD_LATENCY; i++) n = n + {7'd0, v[i]};
        return n;
    endfunction

    // Credits: every slot is either occupied, awaiting read data, or strobed this cycle.
    assign outstanding = 8'(count_q) + inflight(rd_en_q, vld_p);
    assign push        = vld_p[RD_LATENCY-1];
    assign pix_valid   = (count_q != '0);
    assign pop         = pix_valid & bus.pix_ready;

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        issue_go = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
                    if (bus.len == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        issue_go = 1'b1;
                        state_d  = (bus.len == 16'd1) ? DRAIN : FETCH;
                    end
                end
            end
            FETCH: begin
                if (outstanding < DEPTH_C) begin
                    issue_go = 1'b1;
                    if (issued_q + 16'd1 == len_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (sent_q + 16'd1 == len_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: read issue; stages vld_p: read data in flight; then FIFO capture/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            issued_q  <= '0;
            sent_q    <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            done_q    <= 1'b0;
            vld_p     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            rd_en_q <= issue_go;
            if (accept) begin
                base_q <= bus.base;
                len_q  <= bus.len;
            end
            if (issue_go) rd_addr_q <= accept ? bus.base : base_q + issued_q;
            if (accept)        issued_q <= issue_go ? 16'd1 : 16'd0;
            else if (issue_go) issued_q <= issued_q + 16'd1;
            if (accept)   sent_q <= '0;
            else if (pop) sent_q <= sent_q + 16'd1;
            vld_p[0] <= rd_en_q;
            for (int i = 1; i < RD_LATENCY; i++) vld_p[i] <= vld_p[i-1];
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.rd_data;
    end

    assign bus.rd_en      = rd_en_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.pix_valid  = pix_valid;
    assign bus.pix_data   = pix_valid ? fifo_mem[rd_ptr_q] : 8'd0;
    assign bus.bytes_sent = sent_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
endmodule

// File: tb/tb_simple_dma_reader.sv
// Directed bench for simple_dma_reader with address/data scoreboards and stream monitor.
module tb_simple_dma_reader;
    localparam int FIFO_DEPTH = 4;

    logic clk;
    logic rst_n;
    simple_dma_reader_if bus();

    simple_dma_reader #(.RD_LATENCY(1), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: mem[a] = a[7:0], one cycle read latency.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= bus.rd_addr[7:0];
    end

    int          n_cmp, n_mis, cyc;
    int          start_cyc, first_valid_cyc, done_cyc, last_acc_cyc;
    int          done_cnt, rd_cnt, acc_cnt, out_n, max_out;
    int          addr_idx, data_idx;
    bit          first_seen, busy_seen, stalled_prev, busy_at_done;
    logic [7:0]  held;
    logic [15:0] exp_addr[$];
    logic [7:0]  exp_data[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: monitor mid-cycle, then return 1 time unit after the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (!rst_n) begin
            addr_idx     = exp_addr.size();
            data_idx     = exp_data.size();
            out_n        = 0;
            stalled_prev = 1'b0;
        end else begin
            if (bus.busy) busy_seen = 1'b1;
            if (bus.done) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = bus.busy;
            end
            if (bus.rd_en) begin
                rd_cnt++;
                out_n++;
                if (out_n > max_out) max_out = out_n;
                if (addr_idx < exp_addr.size()) begin
                    check("rd_addr", bus.rd_addr, exp_addr[addr_idx]);
                    addr_idx++;
                end else begin
                    check("rd_unexpected", addr_idx, exp_addr.size());
                end
                check("credit_limit", 32'(out_n <= FIFO_DEPTH), 1);
            end
            if (stalled_prev) begin
                check("hold_valid", bus.pix_valid, 1);
                check("hold_data", bus.pix_data, held);
            end
            if (bus.pix_valid && !first_seen) begin
                first_seen      = 1'b1;
                first_valid_cyc = cyc;
            end
            if (bus.pix_valid && bus.pix_ready) begin
                if (data_idx < exp_data.size()) begin
                    check("pix_data", bus.pix_data, exp_data[data_idx]);
                    data_idx++;
                end else begin
                    check("pix_unexpected", data_idx, exp_data.size());
                end
                acc_cnt++;
                out_n--;
                last_acc_cyc = cyc;
            end
            stalled_prev = bus.pix_valid && !bus.pix_ready;
            held         = bus.pix_data;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] l, input bit expect_run);
        logic [15:0] a;
        if (expect_run) begin
            for (int i = 0; i < int'(l); i++) begin
                a = b + 16'(i);
                exp_addr.push_back(a);
                exp_data.push_back(a[7:0]);
            end
        end
        bus.start  = 1'b1;
        bus.base   = b;
        bus.len    = l;
        start_cyc  = cyc;
        first_seen = 1'b0;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_xfer(input bit toggle, input int max_cyc);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < max_cyc && done_cnt == d0; i++) begin
            bus.pix_ready = toggle ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
            tick();
        end
        check("done_seen", done_cnt - d0, 1);
        bus.pix_ready = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},      bus.rd_en, 0);
        check({tag, "_rd_addr"},    bus.rd_addr, 0);
        check({tag, "_pix_valid"},  bus.pix_valid, 0);
        check({tag, "_pix_data"},   bus.pix_data, 0);
        check({tag, "_bytes_sent"}, bus.bytes_sent, 0);
        check({tag, "_busy"},       bus.busy, 0);
        check({tag, "_done"},       bus.done, 0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_addr_drained"}, addr_idx, exp_addr.size());
        check({tag, "_data_drained"}, data_idx, exp_data.size());
    endtask

    initial begin
        int d0, r0, a0;
        n_cmp = 0; n_mis = 0; cyc = 0;
        done_cnt = 0; rd_cnt = 0; acc_cnt = 0; out_n = 0; max_out = 0;
        addr_idx = 0; data_idx = 0;
        first_seen = 1'b0; busy_seen = 1'b0; stalled_prev = 1'b0; busy_at_done = 1'b0;
        held = '0;
        start_cyc = 0; first_valid_cyc = 0; done_cyc = 0; last_acc_cyc = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.base = '0; bus.len = '0; bus.pix_ready = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Basic transfer, full rate.
        do_start(16'h0100, 16'd4, 1'b1);
        check("t1_busy_after_start", bus.busy, 1);
        run_xfer(1'b0, 40);
        check("t1_first_valid_lat", first_valid_cyc - start_cyc, 3);
        check("t1_done_lat", done_cyc - last_acc_cyc, 1);
        check("t1_busy_at_done", busy_at_done, 0);
        check("t1_bytes_sent", bus.bytes_sent, 4);
        check_drained("t1");

        // Backpressure 1-0-0-1: stalls hold data, credits bound the read stream.
        max_out = 0;
        do_start(16'h0200, 16'd16, 1'b1);
        run_xfer(1'b1, 200);
        check("t2_max_outstanding", max_out, FIFO_DEPTH);
        check("t2_bytes_sent", bus.bytes_sent, 16);
        check_drained("t2");

        // Address wrap.
        do_start(16'hFFFE, 16'd4, 1'b1);
        run_xfer(1'b0, 40);
        check("t3_bytes_sent", bus.bytes_sent, 4);
        check_drained("t3");

        // Zero length.
        d0 = done_cnt; r0 = rd_cnt; busy_seen = 1'b0;
        do_start(16'h0700, 16'd0, 1'b0);
        repeat (5) tick();
        check("t4_done_count", done_cnt - d0, 1);
        check("t4_done_lat", done_cyc - start_cyc, 1);
        check("t4_busy_seen", busy_seen, 0);
        check("t4_no_reads", rd_cnt - r0, 0);
        check("t4_no_valid", first_seen, 0);
        check("t4_bytes_sent", bus.bytes_sent, 0);

        // Start while busy is ignored.
        do_start(16'h0300, 16'd8, 1'b1);
        repeat (3) tick();
        bus.start = 1'b1; bus.base = 16'h0550; bus.len = 16'd3;
        tick();
        bus.start = 1'b0;
        run_xfer(1'b0, 60);
        check("t5_bytes_sent", bus.bytes_sent, 8);
        check_drained("t5");
        d0 = done_cnt;
        repeat (5) tick();
        check("t5_no_extra_done", done_cnt - d0, 0);
        check("t5_idle", bus.busy, 0);

        // Reset mid-transfer after 5 of 10 bytes, then a fresh transfer.
        a0 = acc_cnt;
        do_start(16'h0400, 16'd10, 1'b1);
        for (int i = 0; i < 60 && (acc_cnt - a0) < 5; i++) tick();
        check("t6_pre_reset_acc", acc_cnt - a0, 5);
        check("t6_pre_reset_bytes", bus.bytes_sent, 5);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_midreset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_bytes_after_reset", bus.bytes_sent, 0);
        do_start(16'h2000, 16'd6, 1'b1);
        run_xfer(1'b0, 60);
        check("t6_bytes_sent", bus.bytes_sent, 6);
        check_drained("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
